// File: rtl/xmodem_block_rx.sv
// xmodem_block_rx: XMODEM checksum block receiver writing payload bytes to a scene memory; optional inter-byte timeout when XM_TIMEOUT_EN is defined
module xmodem_block_rx #(
  parameter int BLOCK_BYTES = 128,
  parameter int ADDR_W      = 16,
  parameter int TIMEOUT_CYC = 2000000
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              saw_valid_block,
  output logic              xfer_done,
  output logic [ADDR_W-1:0] bytes_rcvd
);
  localparam int OW = BLOCK_BYTES > 1 ? $clog2(BLOCK_BYTES) : 1;
  typedef enum logic [2:0] {IDLE, BNUM, BNUM_C, DATA, CSUM, RESP, DONE} state_t;
  state_t state_q, state_d;
  logic [7:0] exp_q, exp_d, bnum_q, bnum_d, cbnum_q, cbnum_d, sum_q, sum_d, tx_q, tx_d;
  logic [ADDR_W-1:0] blk_q, blk_d, bytes_q, bytes_d;
  logic [OW-1:0] off_q, off_d;
  logic eot_q, eot_d, svb_q, svb_d;
  logic cmp_ok, good, dup, last, csum_ok, tmo;
  assign cmp_ok  = (bnum_q ^ cbnum_q) == 8'hFF;
  assign good    = cmp_ok && bnum_q == exp_q;
  assign dup     = cmp_ok && bnum_q == exp_q - 8'd1;
  assign last    = off_q == OW'(BLOCK_BYTES - 1);
  assign csum_ok = rx_data == sum_q;
`ifdef XM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_q;
  logic in_blk;
  assign in_blk = state_q inside {BNUM, BNUM_C, DATA, CSUM};
  assign tmo    = in_blk && !rx_valid && tmo_q == TW'(TIMEOUT_CYC - 1);
  // idle cycles since the last byte of a block in flight
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) tmo_q <= '0;
    else tmo_q <= (rx_valid || !in_blk) ? '0 : tmo_q + 1'b1;
`else
  assign tmo = 1'b0;
`endif
  // state register
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) state_q <= IDLE;
    else state_q <= state_d;
  // datapath registers
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) begin
      exp_q   <= 8'd1;
      bnum_q  <= '0;
      cbnum_q <= '0;
      sum_q   <= '0;
      tx_q    <= '0;
      blk_q   <= '0;
      bytes_q <= '0;
      off_q   <= '0;
      eot_q   <= 1'b0;
      svb_q   <= 1'b0;
    end else begin
      exp_q   <= exp_d;
      bnum_q  <= bnum_d;
      cbnum_q <= cbnum_d;
      sum_q   <= sum_d;
      tx_q    <= tx_d;
      blk_q   <= blk_d;
      bytes_q <= bytes_d;
      off_q   <= off_d;
      eot_q   <= eot_d;
      svb_q   <= svb_d;
    end
  // next-state: a timeout in any in-block state forces a NAK response
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rx_valid) state_d = rx_data == 8'h01 ? BNUM : rx_data == 8'h04 ? RESP : IDLE;
      BNUM:    state_d = tmo ? RESP : rx_valid ? BNUM_C : BNUM;
      BNUM_C:  state_d = tmo ? RESP : rx_valid ? DATA : BNUM_C;
      DATA:    state_d = tmo ? RESP : (rx_valid && last) ? CSUM : DATA;
      CSUM:    state_d = (tmo || rx_valid) ? RESP : CSUM;
      RESP:    if (tx_ready) state_d = eot_q ? DONE : IDLE;
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  // header latch, running sum, offset and commit of a good block on checksum
  always_comb begin
    exp_d   = exp_q;
    bnum_d  = bnum_q;
    cbnum_d = cbnum_q;
    sum_d   = sum_q;
    tx_d    = tx_q;
    blk_d   = blk_q;
    bytes_d = bytes_q;
    off_d   = off_q;
    eot_d   = eot_q;
    svb_d   = 1'b0;
    case (state_q)
      IDLE: if (rx_valid && rx_data == 8'h04) begin
        tx_d  = 8'h06;
        eot_d = 1'b1;
      end
      BNUM: if (rx_valid) bnum_d = rx_data;
      BNUM_C: if (rx_valid) begin
        cbnum_d = rx_data;
        off_d   = '0;
        sum_d   = '0;
      end
      DATA: if (rx_valid) begin
        sum_d = sum_q + rx_data;
        off_d = last ? '0 : off_q + 1'b1;
      end
      CSUM: if (rx_valid) begin
        tx_d = ((good || dup) && csum_ok) ? 8'h06 : 8'h15;
        if (good && csum_ok) begin
          exp_d   = exp_q + 8'd1;
          blk_d   = blk_q + 1'b1;
          bytes_d = bytes_q + ADDR_W'(BLOCK_BYTES);
          svb_d   = 1'b1;
        end
      end
      default: ;
    endcase
    if (tmo) tx_d = 8'h15;
  end
  // outputs decoded from state and registers
  always_comb begin
    tx_valid        = state_q == RESP;
    xfer_done       = state_q == DONE;
    wr_en           = state_q == DATA && rx_valid && good;
    wr_addr         = blk_q * ADDR_W'(BLOCK_BYTES) + ADDR_W'(off_q);
    wr_data         = rx_data;
    tx_data         = tx_q;
    saw_valid_block = svb_q;
    bytes_rcvd      = bytes_q;
  end
endmodule

// File: doc/xmodem_block_rx.md
XMODEM_BLOCK_RX -- requirements
Module: xmodem_block_rx

Interface
REQ-001 SHALL provide parameter BLOCK_BYTES, default 128, data bytes per XMODEM block.
REQ-002 SHALL provide parameter ADDR_W, default 16, byte-address width of the scene write port.
REQ-003 SHALL provide parameter TIMEOUT_CYC, default 2000000, inter-byte timeout in clk cycles.
REQ-004 SHALL have ports: clk  in  1  system clock; rst_b  in  1  asynchronous active-low reset.
REQ-005 SHALL have ports: rx_data  in  8  UART byte; rx_valid  in  1  one-cycle strobe per received byte.
REQ-006 SHALL have ports: tx_data  out  8  response byte; tx_valid  out  1  response pending; tx_ready  in  1  UART transmitter accepts.
REQ-007 SHALL have ports: wr_en  out  1  scene byte write; wr_addr  out  ADDR_W  byte address; wr_data  out  8  byte.
REQ-008 SHALL have ports: saw_valid_block  out  1  one-cycle pulse per committed block; xfer_done  out  1  level, EOT received; bytes_rcvd  out  ADDR_W  committed byte count.

Function
REQ-009 SHALL implement states IDLE, BNUM, BNUM_C, DATA, CSUM, RESP, DONE; a byte is consumed only in a cycle with rx_valid=1.
REQ-010 IDLE: 0x01 (SOH) -> BNUM; 0x04 (EOT) -> load tx_data=0x06, RESP, then DONE; any other byte ignored, stay IDLE.
REQ-011 BNUM: latch block number -> BNUM_C; BNUM_C: latch complement, clear offset and 8-bit running sum -> DATA.
REQ-012 Header classes: good = (bnum == expected) and (bnum ^ cbnum == 0xFF); duplicate = (bnum == expected-1 mod 256) and complement ok; otherwise bad.
REQ-013 DATA: each byte adds to sum (mod 256); for good header, wr_en=1 same cycle as rx_valid, wr_addr = blk_idx*BLOCK_BYTES + offset, wr_data = rx_data; duplicate/bad: no writes.
REQ-014 DATA -> CSUM after the BLOCK_BYTES-th byte; offset counts 0..BLOCK_BYTES-1.
REQ-015 CSUM: good header and byte == sum -> tx_data=0x06 (ACK), expected+=1 (wraps 255->0), blk_idx+=1, bytes_rcvd+=BLOCK_BYTES, saw_valid_block pulses the next cycle.
REQ-016 CSUM: duplicate header with matching checksum -> ACK, no counters change; any other case -> tx_data=0x15 (NAK), no counters change.
REQ-017 Retransmitted good block after NAK SHALL rewrite the same addresses (blk_idx unchanged).
REQ-018 RESP: tx_valid=1, tx_data stable until cycle with tx_ready=1; then -> IDLE (or DONE after EOT ACK); rx bytes arriving in RESP are dropped.
REQ-019 DONE: xfer_done=1, all rx bytes ignored, no writes, until reset.
REQ-020 wr_addr arithmetic SHALL truncate to ADDR_W bits (wraps silently).
REQ-021 wr_en, tx_valid, saw_valid_block SHALL never be asserted in the same cycle as each other except saw_valid_block with tx_valid.

Reset
REQ-022 rst_b=0 SHALL immediately force IDLE, expected=1, blk_idx=0, bytes_rcvd=0, sum=0, offset=0, tx_data=0, and all strobes/xfer_done low.
REQ-023 Reset mid-block or mid-RESP SHALL abandon the block with no response byte and no further writes.

Configuration
REQ-024 With XM_TIMEOUT_EN defined: in BNUM, BNUM_C, DATA, CSUM a counter reloads on each rx_valid; reaching TIMEOUT_CYC cycles without a byte -> tx_data=0x15, RESP, no counter changes.
REQ-025 Without XM_TIMEOUT_EN: no timeout counter is synthesised; a stalled block waits indefinitely.

Verification
REQ-026 Blocks 1,2 of 128 bytes 0x00..0x7F, correct sums -> 256 writes at addr 0..255, two ACK 0x06, two saw_valid_block pulses, bytes_rcvd=256.
REQ-027 Block 1 with checksum-1, then correct block 1 -> NAK 0x15, then ACK; addr 0..127 rewritten; bytes_rcvd=128.
REQ-028 Block 1 sent twice, both correct -> second gets ACK, zero writes, bytes_rcvd=128, one saw_valid_block pulse.
REQ-029 SOH, bnum=0x01, cbnum=0xFF -> 128+1 bytes consumed, no writes, NAK.
REQ-030 EOT with tx_ready held low 10 cycles -> tx_valid=1, tx_data=0x06 held 10 cycles; after accept xfer_done=1; later SOH ignored.
REQ-031 With XM_TIMEOUT_EN, TIMEOUT_CYC=100: stop after 40 data bytes -> NAK exactly 100 cycles after last byte; rst_b pulse mid-block -> IDLE, no tx_valid.
